// File: rtl/bruin_physics.sv
// Bruin sprite physics: gravity/flap velocity model plus IDLE/PLAY/DEAD play state.
// Define BRUIN_CEIL_KILL_EN to make touching the ceiling lethal.
module bruin_physics #(
    parameter int Y_W           = 9,
    parameter int VEL_W         = 6,
    parameter int X_POS         = 150,
    parameter int SPRITE_H      = 20,
    parameter int SPRITE_W      = 20,
    parameter int Y_INIT        = 240,
    parameter int Y_MIN         = 10,
    parameter int Y_MAX         = 470,
    parameter int GRAVITY       = 1,
    parameter int FLAP_VEL      = 6,
    parameter int VMAX_FALL     = 8,
    parameter int FLAP_COOLDOWN = 4
) (
    input  logic                    clk_100MHz,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic                    game_start,
    input  logic                    flap,
    input  logic                    lose,
    output logic [Y_W-1:0]          x,
    output logic [Y_W-1:0]          y,
    output logic [4:0]              high,
    output logic [4:0]              width,
    output logic signed [VEL_W-1:0] vel,
    output logic                    game_over,
    output logic [1:0]              state
);

    localparam int CD_W = (FLAP_COOLDOWN > 0) ? $clog2(FLAP_COOLDOWN + 1) : 1;
    localparam int YS_W = Y_W + 2;

    localparam logic signed [VEL_W:0]   GRAV_S   = (VEL_W + 1)'(GRAVITY);
    localparam logic signed [VEL_W:0]   VMAX_S   = (VEL_W + 1)'(VMAX_FALL);
    localparam logic [VEL_W-1:0]        FLAP_NEG = VEL_W'(-FLAP_VEL);
    localparam logic signed [YS_W-1:0]  YMAX_S   = YS_W'(Y_MAX);
    localparam logic signed [YS_W-1:0]  YMIN_S   = YS_W'(Y_MIN);
    localparam logic [CD_W-1:0]         CD_LOAD  = CD_W'(FLAP_COOLDOWN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    s1_q, s2_q, s3_q;
    logic                    flap_pend_q, flap_pend_d;
    logic [Y_W-1:0]          y_q, y_d;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic [CD_W-1:0]         cd_q, cd_d;

    logic                    flap_edge, accept, step;
    logic signed [VEL_W:0]   vel_g;
    logic signed [VEL_W-1:0] vel_fall, vel_n;
    logic signed [YS_W-1:0]  y_n;
    logic                    hit_floor, hit_ceil;

    // s1/s2 synchronize the raw button, s3 holds the previous level for edge detect
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= flap;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign flap_edge = s2_q & ~s3_q;
    assign step      = (state_q == PLAY) && frame_tick && !lose;
    assign accept    = (flap_pend_q | flap_edge) && (cd_q == '0);

    assign vel_g     = {vel_q[VEL_W-1], vel_q} + GRAV_S;
    assign vel_fall  = (vel_g > VMAX_S) ? VMAX_S[VEL_W-1:0] : vel_g[VEL_W-1:0];
    assign vel_n     = accept ? FLAP_NEG : vel_fall;

    // Widened sum so a large upward velocity near the top cannot wrap
    assign y_n       = $signed({2'b00, y_q})
                     + $signed({{(YS_W - VEL_W){vel_n[VEL_W-1]}}, vel_n});
    assign hit_floor = (y_n >= YMAX_S);
    assign hit_ceil  = (y_n <= YMIN_S);

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (game_start) state_d = PLAY;
            PLAY: begin
                if (lose)                       state_d = DEAD;
                else if (step && hit_floor)     state_d = DEAD;
`ifdef BRUIN_CEIL_KILL_EN
                else if (step && hit_ceil)      state_d = DEAD;
`endif
            end
            DEAD:    state_d = DEAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        game_over = (state_q == DEAD);
        state     = state_q;
    end

    always_comb begin
        flap_pend_d = flap_pend_q;
        y_d         = y_q;
        vel_d       = vel_q;
        cd_d        = cd_q;
        if (state_q == IDLE) begin
            flap_pend_d = 1'b0;
            y_d         = Y_W'(Y_INIT);
            vel_d       = '0;
            cd_d        = '0;
        end else if (state_q == PLAY && frame_tick) begin
            flap_pend_d = 1'b0;
        end else if (flap_edge) begin
            flap_pend_d = 1'b1;
        end
        if (step) begin
            if (accept)          cd_d = CD_LOAD;
            else if (cd_q != '0) cd_d = cd_q - CD_W'(1);
            if (hit_floor) begin
                y_d   = Y_W'(Y_MAX);
                vel_d = '0;
            end else if (hit_ceil) begin
                y_d   = Y_W'(Y_MIN);
                vel_d = '0;
            end else begin
                y_d   = y_n[Y_W-1:0];
                vel_d = vel_n;
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            flap_pend_q <= 1'b0;
            y_q         <= Y_W'(Y_INIT);
            vel_q       <= '0;
            cd_q        <= '0;
        end else begin
            flap_pend_q <= flap_pend_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
            cd_q        <= cd_d;
        end
    end

    assign x     = Y_W'(X_POS);
    assign high  = 5'(SPRITE_H);
    assign width = 5'(SPRITE_W);
    assign y     = y_q;
    assign vel   = vel_q;

endmodule

// File: tb/tb_bruin_physics.sv
// Scoreboard bench for bruin_physics: integer game model feeds a queue,
// a monitor pops and checks one cycle after every tick or explicit check.
module tb_bruin_physics;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       game_start = 1'b0;
    logic       flap = 1'b0;
    logic       lose = 1'b0;
    logic [8:0] x, y;
    logic [4:0] high, width;
    logic [5:0] vel;
    logic       game_over;
    logic [1:0] state;

    always #5 clk = ~clk;

    bruin_physics dut (
        .clk_100MHz (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .game_start (game_start),
        .flap       (flap),
        .lose       (lose),
        .x          (x),
        .y          (y),
        .high       (high),
        .width      (width),
        .vel        (vel),
        .game_over  (game_over),
        .state      (state)
    );

    typedef struct {
        int y;
        int v;
        int s;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_req = 1'b0;
    logic seen = 1'b0;

    // Reference game model
    int my, mv, ms, mcd;
    bit mp;

    task automatic cmp(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    always @(posedge clk) seen <= frame_tick | chk_req;

    always @(negedge clk) begin
        exp_t e;
        if (seen) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty: got output with no expectation");
            end else begin
                e = q.pop_front();
                cmp("y", int'(y), e.y);
                cmp("vel", int'($signed(vel)), e.v);
                cmp("state", int'(state), e.s);
                cmp("game_over", int'(game_over), (e.s == 2) ? 1 : 0);
                cmp("x", int'(x), 150);
                cmp("high", int'(high), 20);
                cmp("width", int'(width), 20);
            end
        end
    end

    function automatic void push_exp();
        exp_t e;
        e.y = my;
        e.v = mv;
        e.s = ms;
        q.push_back(e);
    endfunction

    function automatic void model_reset();
        my = 240; mv = 0; ms = 0; mcd = 0; mp = 0;
    endfunction

    function automatic void model_tick(bit l);
        int yn;
        if (ms != 1) return;
        if (l) begin
            ms = 2;
        end else begin
            if (mp && mcd == 0) begin
                mv  = -6;
                mcd = 4;
            end else begin
                mv = (mv + 1 > 8) ? 8 : mv + 1;
                if (mcd > 0) mcd--;
            end
            yn = my + mv;
            if (yn >= 470) begin
                my = 470; mv = 0; ms = 2;
            end else if (yn <= 10) begin
                my = 10; mv = 0;
`ifdef BRUIN_CEIL_KILL_EN
                ms = 2;
`endif
            end else begin
                my = yn;
            end
        end
        mp = 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        flap = 0; frame_tick = 0; lose = 0; game_start = 0;
        #2 rst = 1;
        model_reset();
        push_exp();
        chk_req = 1;
        @(negedge clk);
        chk_req = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic tick(input bit l);
        @(negedge clk);
        frame_tick = 1;
        lose = l;
        model_tick(l);
        push_exp();
        @(negedge clk);
        frame_tick = 0;
        lose = 0;
    endtask

    task automatic start();
        @(negedge clk);
        game_start = 1;
        chk_req = 1;
        if (ms == 0) ms = 1;
        push_exp();
        @(negedge clk);
        game_start = 0;
        chk_req = 0;
    endtask

    task automatic do_flap();
        @(negedge clk);
        flap = 1;
        repeat (4) @(negedge clk);
        flap = 0;
        repeat (3) @(negedge clk);
        if (ms == 1) mp = 1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        do_reset();

        // Free fall, flap, cooldown, floor
        start();
        repeat (3) tick(0);
        do_flap();
        tick(0);
        do_flap();
        tick(0);
        repeat (3) tick(0);
        do_flap();
        tick(0);
        for (int i = 0; i < 100 && ms == 1; i++) tick(0);
        repeat (2) tick(0);
        start();

        // Lose coincident with a tick
        do_reset();
        start();
        repeat (2) tick(0);
        tick(1);
        tick(0);

        // Climb to the ceiling
        do_reset();
        start();
        for (int i = 0; i < 40 && ms == 1; i++) begin
            do_flap();
            tick(0);
        end

        // Randomized games
        repeat (10) begin
            do_reset();
            start();
            repeat (40) begin
                r = $urandom_range(0, 19);
                if (r < 12)       tick(0);
                else if (r < 18)  do_flap();
                else if (r == 18) start();
                else              tick(1);
            end
        end

        repeat (3) @(negedge clk);
        cmp("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
